// File: rtl/crc_frame_checker.sv
// Purpose: sequences a 1-Wire frame through the bit-serial Dallas/Maxim CRC-8 and flags a good frame.
// Latency: 9 cycles per byte (1 accept + 8 shift); done one cycle after the last shift, one cycle after start for len 0.
// Backpressure: byte_ready only in WAIT_BYTE; a byte offered at any other time stays with the sender.

// Bit-serial CRC-8, polynomial x^8+x^5+x^4+1, reflected (LSB-first input).
// crc_nxt exposes the value the register would take if enabled this cycle.
module crc8_maxim_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       b,
    output logic [7:0] crc,
    output logic [7:0] crc_nxt
);
    logic [7:0] c;
    logic       f;

    // Feedback taps for one reflected CRC step.
    always_comb begin
        f       = b ^ c[0];
        crc_nxt = {f, c[7:5], c[4] ^ f, c[3] ^ f, c[2:1]};
    end

    // CRC register: cleared by reset or clear strobe, advances one bit when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            c <= 8'h00;
        end else if (en) begin
            c <= crc_nxt;
        end
    end

    assign crc = c;
endmodule

module crc_frame_checker #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic [7:0]       crc_value
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic [LEN_W-1:0] byte_cnt_inc;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             ok_q;

    logic             load_frame;   // start accepted in IDLE
    logic             accept;       // byte handshake this cycle
    logic             shift_step;   // one CRC bit consumed this cycle
    logic             last_bit;     // eighth bit of the current byte
    logic             frame_end;    // last bit of the last byte
    logic             kill;         // abort of an active frame
    logic             crc_clr;
    logic [7:0]       crc_q;
    logic [7:0]       crc_nxt;

    crc8_maxim_serial u_crc (
        .clk     (clk),
        .rst     (rst | crc_clr),
        .en      (shift_step),
        .b       (shift_q[0]),
        .crc     (crc_q),
        .crc_nxt (crc_nxt)
    );

    // Next-state and strobe decode; abort overrides every other event.
    always_comb begin
        state_d      = state_q;
        load_frame   = 1'b0;
        accept       = 1'b0;
        shift_step   = 1'b0;
        frame_end    = 1'b0;
        crc_clr      = 1'b0;
        kill         = 1'b0;
        last_bit     = (bit_cnt_q == 3'd7);
        byte_cnt_inc = byte_cnt_q + LEN_W'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_frame = 1'b1;
                    crc_clr    = 1'b1;
                    state_d    = (len == '0) ? DONE : WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (byte_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_step = 1'b1;
                if (last_bit) begin
                    if (byte_cnt_inc == len_q) begin
                        frame_end = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = WAIT_BYTE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort && (state_q != IDLE)) begin
            kill       = 1'b1;
            accept     = 1'b0;
            shift_step = 1'b0;
            frame_end  = 1'b0;
            state_d    = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame length, counters, byte shifter and the registered pass flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            ok_q       <= 1'b0;
        end else if (load_frame) begin
            len_q      <= len;
            byte_cnt_q <= '0;
            // An empty frame leaves the freshly cleared register, which is a pass.
            ok_q       <= (len == '0);
        end else if (kill) begin
            ok_q <= 1'b0;
        end else begin
            if (accept) begin
                shift_q   <= byte_in;
                bit_cnt_q <= 3'd0;
            end
            if (shift_step) begin
                shift_q   <= {1'b0, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (last_bit) begin
                    byte_cnt_q <= byte_cnt_inc;
                end
            end
            // Judge on the value the CRC takes at this edge so crc_ok lines up with done.
            if (frame_end) begin
                ok_q <= (crc_nxt == 8'h00);
            end
        end
    end

    assign byte_ready = (state_q == WAIT_BYTE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign crc_ok     = ok_q;
    assign crc_value  = crc_q;
endmodule

// File: tb/tb_crc_frame_checker.sv
module tb_crc_frame_checker;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic [7:0]       crc_value;

    crc_frame_checker #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .crc_ok     (crc_ok),
        .crc_value  (crc_value)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] fb [16];
    int         fg [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference CRC: one byte, LSB first, reflected polynomial 0x8C.
    function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       f;
        r = c;
        for (int i = 0; i < 8; i++) begin
            f = d[i] ^ r[0];
            r = r >> 1;
            if (f) r = r ^ 8'h8C;
        end
        return r;
    endfunction

    function automatic logic [7:0] crc_list(input int n);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < n; i++) r = crc_byte(r, fb[i]);
        return r;
    endfunction

    // Behavioural model: frame-level bookkeeping with byte-wise CRC.
    logic       m_busy, m_ready, m_done, m_ok, m_known;
    logic [7:0] m_crc;
    int         m_shift, m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_done <= 1'b0; m_ok <= 1'b0;
            m_crc <= 8'h00; m_known <= 1'b1; m_shift <= 0; m_left <= 0;
        end else if (m_busy && abort) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_done <= 1'b0; m_ok <= 1'b0;
            if (m_shift != 0) m_known <= 1'b0;
            m_shift <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy  <= 1'b1;
                m_crc   <= 8'h00;
                m_known <= 1'b1;
                m_left  <= int'(len);
                if (len == 0) begin
                    m_done <= 1'b1;
                    m_ok   <= 1'b1;
                end else begin
                    m_ready <= 1'b1;
                    m_ok    <= 1'b0;
                end
            end
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_ready) begin
            if (byte_valid) begin
                m_crc   <= crc_byte(m_crc, byte_in);
                m_ready <= 1'b0;
                m_shift <= 8;
            end
        end else begin
            m_shift <= m_shift - 1;
            if (m_shift == 1) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_ok   <= (m_crc == 8'h00);
                end else begin
                    m_ready <= 1'b1;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("byte_ready", 32'(byte_ready), 32'(m_ready));
            check("done", 32'(done), 32'(m_done));
            check("crc_ok", 32'(crc_ok), 32'(m_ok));
            if (m_known && m_shift == 0) check("crc_value", 32'(crc_value), 32'(m_crc));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from fb/fg. inj_at: byte index before which a stray start is pulsed.
    // abort_at / rst_at: byte index after whose handshake the frame is cut short.
    task automatic run_frame(input int n, input int inj_at, input int abort_at, input int rst_at,
                             output int lat);
        int s_cyc;
        int w;
        lat   = -1;
        start = 1'b1;
        len   = LEN_W'(n);
        s_cyc = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == inj_at) begin
                start = 1'b1;
                len   = LEN_W'(1);
                tick();
                start = 1'b0;
            end
            repeat (fg[i]) tick();
            byte_valid = 1'b1;
            byte_in    = fb[i];
            w = 0;
            while (w < 40) begin
                @(negedge clk);
                if (byte_ready) break;
                w++;
            end
            if (w == 40) begin
                check("byte_ready_timeout", 32'(w), 32'(0));
                byte_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
            if (i == abort_at) begin
                repeat (3) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
                return;
            end
            if (i == rst_at) begin
                repeat (2) tick();
                rst = 1'b1;
                tick();
                return;
            end
        end
        w = 0;
        while (w < 40) begin
            @(negedge clk);
            if (done) break;
            w++;
        end
        if (w == 40) check("done_timeout", 32'(w), 32'(0));
        else lat = cyc - s_cyc;
    endtask

    task automatic load_a;
        fb[0] = 8'h02; fb[1] = 8'h1C; fb[2] = 8'hB8; fb[3] = 8'h01;
        fb[4] = 8'h00; fb[5] = 8'h00; fb[6] = 8'h00; fb[7] = 8'hA2;
        for (int i = 0; i < 16; i++) fg[i] = 0;
    endtask

    int lat;
    int seen_done;
    logic [7:0] exp_crc;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        len = '0; byte_in = 8'h00;

        // Pin the model against hand-known Dallas CRC values.
        load_a();
        check("model_vecA", 32'(crc_list(8)), 32'h00);
        check("model_vecB", 32'(crc_list(7)), 32'hA2);
        check("model_01", 32'(crc_byte(8'h00, 8'h01)), 32'h5E);

        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(byte_ready), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ok", 32'(crc_ok), 32'(0));
        check("rst_crc", 32'(crc_value), 32'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Vector A, byte_valid held high.
        load_a();
        run_frame(8, -1, -1, -1, lat);
        check("A_latency", 32'(lat), 32'(73));
        check("A_crc", 32'(crc_value), 32'h00);
        check("A_ok", 32'(crc_ok), 32'(1));
        tick();

        // Vector B: first seven bytes only, back-to-back with the previous frame.
        run_frame(7, -1, -1, -1, lat);
        check("B_latency", 32'(lat), 32'(64));
        check("B_crc", 32'(crc_value), 32'hA2);
        check("B_ok", 32'(crc_ok), 32'(0));
        tick();

        // Corrupted third byte.
        fb[2] = 8'hB9;
        exp_crc = crc_list(8);
        run_frame(8, -1, -1, -1, lat);
        check("corrupt_crc", 32'(crc_value), 32'(exp_crc));
        check("corrupt_ok", 32'(crc_ok), 32'(0));
        tick();

        // Single-byte frames.
        fb[0] = 8'h01;
        run_frame(1, -1, -1, -1, lat);
        check("one_01_latency", 32'(lat), 32'(10));
        check("one_01_crc", 32'(crc_value), 32'h5E);
        check("one_01_ok", 32'(crc_ok), 32'(0));
        tick();
        fb[0] = 8'h00;
        run_frame(1, -1, -1, -1, lat);
        check("one_00_crc", 32'(crc_value), 32'h00);
        check("one_00_ok", 32'(crc_ok), 32'(1));
        tick();

        // Gapped handshake with a stray start mid-frame.
        load_a();
        fg[0] = 0; fg[1] = 3; fg[2] = 5; fg[3] = 1;
        fg[4] = 2; fg[5] = 0; fg[6] = 4; fg[7] = 5;
        run_frame(8, 2, -1, -1, lat);
        check("gap_crc", 32'(crc_value), 32'h00);
        check("gap_ok", 32'(crc_ok), 32'(1));
        tick();

        // Empty frame.
        run_frame(0, -1, -1, -1, lat);
        check("len0_latency", 32'(lat), 32'(1));
        check("len0_ok", 32'(crc_ok), 32'(1));
        tick();

        // Abort during the shift of the fourth byte.
        load_a();
        run_frame(8, -1, 3, -1, lat);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_ok", 32'(crc_ok), 32'(0));
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'(0));
        @(posedge clk); #1;
        run_frame(8, -1, -1, -1, lat);
        check("after_abort_crc", 32'(crc_value), 32'h00);
        check("after_abort_ok", 32'(crc_ok), 32'(1));
        tick();

        // Reset mid-frame.
        run_frame(8, -1, -1, 1, lat);
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_ready", 32'(byte_ready), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_ok", 32'(crc_ok), 32'(0));
        check("midrst_crc", 32'(crc_value), 32'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Longest frame: 14 data bytes plus their CRC.
        for (int i = 0; i < 14; i++) fb[i] = 8'((i * 17) + 3);
        fb[14] = crc_list(14);
        for (int i = 0; i < 16; i++) fg[i] = 0;
        run_frame(15, -1, -1, -1, lat);
        check("max_latency", 32'(lat), 32'(136));
        check("max_crc", 32'(crc_value), 32'h00);
        check("max_ok", 32'(crc_ok), 32'(1));
        repeat (3) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
